core_dequant: RTL and testbench



---
 rtl/core_dequant_pkg.sv | 24 ++
 rtl/core_dequant_if.sv | 24 ++
 rtl/core_dequant_round_sat.sv | 43 ++++
 rtl/core_dequant.sv | 101 ++++++++++
 tb/tb_core_dequant.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/core_dequant_pkg.sv
// rtl/core_dequant_pkg.sv - shared widths, product sizing and output range constants for core_dequant.
package core_dequant_pkg;

    localparam int DQ_IDATA_BIT = 8;

    localparam int DQ_ODATA_BIT = 32;

    localparam int DQ_SHIFT_BIT = 5;

    // diff carries one extra bit so idata - zp never wraps
    function automatic int dq_prod_bit(input int ibit, input int obit);
        return ibit + 1 + obit;
    endfunction

    function automatic int dq_shift_max(input int prod_bit);
        return prod_bit - 1;
    endfunction

    localparam int DQ_PROD_BIT = dq_prod_bit(DQ_IDATA_BIT, DQ_ODATA_BIT);

    localparam logic [DQ_ODATA_BIT-1:0] DQ_OMAX = {1'b0, {(DQ_ODATA_BIT-1){1'b1}}};
    localparam logic [DQ_ODATA_BIT-1:0] DQ_OMIN = {1'b1, {(DQ_ODATA_BIT-1){1'b0}}};

endpackage

// File: rtl/core_dequant_if.sv
// rtl/core_dequant_if.sv - input and output valid/ready streams of core_dequant.
interface core_dequant_if
    import core_dequant_pkg::*;
#(
    parameter int IDATA_BIT = DQ_IDATA_BIT,
    parameter int ODATA_BIT = DQ_ODATA_BIT
);
    logic signed [IDATA_BIT-1:0] idata;
    logic                        idata_valid;
    logic                        idata_ready;
    logic signed [ODATA_BIT-1:0] odata;
    logic                        odata_valid;
    logic                        odata_ready;

    modport master (
        output idata, idata_valid, odata_ready,
        input  idata_ready, odata, odata_valid
    );

    modport slave (
        input  idata, idata_valid, odata_ready,
        output idata_ready, odata, odata_valid
    );
endinterface

// File: rtl/core_dequant_round_sat.sv
// rtl/core_dequant_round_sat.sv - combinational round-half-up right shift and saturation of the product.
module core_dequant_round_sat
    import core_dequant_pkg::*;
#(
    parameter int PROD_BIT  = DQ_PROD_BIT,
    parameter int ODATA_BIT = DQ_ODATA_BIT,
    parameter int SHIFT_BIT = DQ_SHIFT_BIT
) (
    input  logic signed [PROD_BIT-1:0]  prod,
    input  logic        [SHIFT_BIT-1:0] shift,
    output logic signed [ODATA_BIT-1:0] odata,
    output logic                        sat
);
    localparam int SMAX = dq_shift_max(PROD_BIT);
    localparam int XW   = PROD_BIT + 1;
    localparam logic signed [XW-1:0] MAX_X = {{(XW-ODATA_BIT+1){1'b0}}, {(ODATA_BIT-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X = {{(XW-ODATA_BIT+1){1'b1}}, {(ODATA_BIT-1){1'b0}}};

    logic        [31:0]   sh;
    logic signed [XW-1:0] wide;
    logic signed [XW-1:0] bias;
    logic signed [XW-1:0] r;

    // one guard bit above the product keeps the rounding carry
    always_comb begin
        sh   = (32'(shift) > 32'(SMAX)) ? 32'(SMAX) : 32'(shift);
        wide = {prod[PROD_BIT-1], prod};
        bias = '0;
        if (sh != 32'd0) begin
            bias = XW'(1) << (sh - 32'd1);
        end
        r     = (wide + bias) >>> sh;
        sat   = 1'b0;
        odata = r[ODATA_BIT-1:0];
        if (r > MAX_X) begin
            odata = MAX_X[ODATA_BIT-1:0];
            sat   = 1'b1;
        end else if (r < MIN_X) begin
            odata = MIN_X[ODATA_BIT-1:0];
            sat   = 1'b1;
        end
    end
endmodule

// File: rtl/core_dequant.sv
// rtl/core_dequant.sv - 3-stage dequantizer sat(round(((x - zp) * scale) >>> shift)) with valid/ready.
// Optional saturation counter: CORE_DEQUANT_SAT_CNT_EN.
module core_dequant
    import core_dequant_pkg::*;
#(
    parameter int IDATA_BIT = DQ_IDATA_BIT,
    parameter int ODATA_BIT = DQ_ODATA_BIT,
    parameter int SHIFT_BIT = DQ_SHIFT_BIT
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [IDATA_BIT-1:0] cfg_dequant_zp,
    input  logic signed [ODATA_BIT-1:0] cfg_dequant_scale,
    input  logic        [SHIFT_BIT-1:0] cfg_dequant_shift,
    core_dequant_if.slave               dif,
`ifdef CORE_DEQUANT_SAT_CNT_EN
    input  logic                        sat_cnt_clr,
    output logic        [15:0]          sat_cnt,
`endif
    output logic                        busy
);
    localparam int DIFF_BIT = IDATA_BIT + 1;
    localparam int PROD_BIT = dq_prod_bit(IDATA_BIT, ODATA_BIT);

    logic                       v1, v2;
    logic                       rdy1, rdy2, rdy3;
    logic signed [DIFF_BIT-1:0] diff_q;
    logic signed [PROD_BIT-1:0] prod_q;
    logic signed [ODATA_BIT-1:0] rs_data;
    logic                       rs_sat;

    // ready ripples back combinationally so a full pipe still moves every cycle
    assign rdy3            = ~dif.odata_valid | dif.odata_ready;
    assign rdy2            = ~v2 | rdy3;
    assign rdy1            = ~v1 | rdy2;
    assign dif.idata_ready = rdy1;
    assign busy            = v1 | v2 | dif.odata_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1     <= 1'b0;
            diff_q <= '0;
        end else if (rdy1) begin
            v1 <= dif.idata_valid;
            if (dif.idata_valid) begin
                diff_q <= DIFF_BIT'(dif.idata) - DIFF_BIT'(cfg_dequant_zp);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2     <= 1'b0;
            prod_q <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                prod_q <= PROD_BIT'(diff_q) * PROD_BIT'(cfg_dequant_scale);
            end
        end
    end

    core_dequant_round_sat #(
        .PROD_BIT  (PROD_BIT),
        .ODATA_BIT (ODATA_BIT),
        .SHIFT_BIT (SHIFT_BIT)
    ) u_round_sat (
        .prod  (prod_q),
        .shift (cfg_dequant_shift),
        .odata (rs_data),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dif.odata_valid <= 1'b0;
            dif.odata       <= '0;
        end else if (rdy3) begin
            dif.odata_valid <= v2;
            if (v2) begin
                dif.odata <= rs_data;
            end
        end
    end

`ifdef CORE_DEQUANT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt <= 16'd0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= 16'd0;
        end else if (rdy3 && v2 && rs_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = rs_sat;
`endif

endmodule

// File: tb/tb_core_dequant.sv
// tb/tb_core_dequant.sv - directed vector and handshake checks for core_dequant.
module tb_core_dequant;
    import core_dequant_pkg::*;

    logic        clk;
    logic        rstn;
    logic signed [7:0]  cfg_zp;
    logic signed [31:0] cfg_scale;
    logic        [4:0]  cfg_shift;
    logic               busy;
`ifdef CORE_DEQUANT_SAT_CNT_EN
    logic               sat_cnt_clr;
    logic        [15:0] sat_cnt;
    int                 exp_sat_cnt;
`endif

    int checks;
    int errors;

    core_dequant_if #(.IDATA_BIT(8), .ODATA_BIT(32)) dif ();

    core_dequant #(.IDATA_BIT(8), .ODATA_BIT(32), .SHIFT_BIT(5)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .cfg_dequant_zp    (cfg_zp),
        .cfg_dequant_scale (cfg_scale),
        .cfg_dequant_shift (cfg_shift),
        .dif               (dif),
`ifdef CORE_DEQUANT_SAT_CNT_EN
        .sat_cnt_clr       (sat_cnt_clr),
        .sat_cnt           (sat_cnt),
`endif
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] x;
        logic signed [7:0] zp;
        logic [31:0]       scale;
        logic [4:0]        shift;
        logic [31:0]       exp;
        logic              sat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_one(input logic signed [7:0] x, input logic signed [7:0] zp,
                           input logic [31:0] sc, input logic [4:0] sh,
                           input logic [31:0] exp, input string nm);
        int lat;
        cfg_zp           = zp;
        cfg_scale        = sc;
        cfg_shift        = sh;
        dif.odata_ready  = 1'b1;
        dif.idata        = x;
        dif.idata_valid  = 1'b1;
        @(posedge clk); #1;
        dif.idata_valid  = 1'b0;
        lat = 1;
        while (!dif.odata_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        chk({nm, "_data"}, dif.odata, exp);
        @(posedge clk); #1;
    endtask

    task automatic stream_test;
        int cyc, idx, got;
        logic prev_stall, saw_drop;
        logic [31:0] prev_val;
        cfg_zp = 8'sd0; cfg_scale = 32'sd2; cfg_shift = 5'd0;
        cyc = 0; idx = 0; got = 0; prev_stall = 1'b0; saw_drop = 1'b0; prev_val = '0;
        while (got < 10 && cyc < 100) begin
            dif.odata_ready = !(cyc >= 4 && cyc <= 8);
            dif.idata_valid = (idx < 10);
            dif.idata       = 8'(idx);
            @(negedge clk);
            if (dif.idata_valid && !dif.idata_ready) saw_drop = 1'b1;
            if (dif.odata_valid) begin
                if (prev_stall) chk("stall_hold", dif.odata, prev_val);
                if (dif.odata_ready) begin
                    chk("stream_data", dif.odata, 32'(2 * got));
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_val   = dif.odata;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (dif.idata_valid && dif.idata_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        dif.idata_valid = 1'b0;
        dif.odata_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd10);
        chk("stream_ready_drop", {31'd0, saw_drop}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("stream_no_extra", {31'd0, dif.odata_valid}, 32'd0);
        end
        chk("stream_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        cfg_zp = '0; cfg_scale = '0; cfg_shift = '0;
        dif.idata = '0; dif.idata_valid = 1'b0; dif.odata_ready = 1'b1;
`ifdef CORE_DEQUANT_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
        exp_sat_cnt = 0;
`endif

        vecs[0] = '{8'sd10,   8'sd2,    32'd3,          5'd0,  32'd24,        1'b0};
        vecs[1] = '{8'sd5,    8'sd0,    32'd1,          5'd1,  32'd3,         1'b0};
        vecs[2] = '{-8'sd5,   8'sd0,    32'd1,          5'd1,  32'hFFFFFFFE,  1'b0};
        vecs[3] = '{-8'sd128, 8'sd127,  32'h7FFFFFFF,   5'd0,  DQ_OMIN,       1'b1};
        vecs[4] = '{8'sd127,  -8'sd128, 32'h7FFFFFFF,   5'd0,  DQ_OMAX,       1'b1};
        vecs[5] = '{8'sd1,    8'sd0,    32'd1,          5'd31, 32'd0,         1'b0};
        vecs[6] = '{8'sd1,    8'sd0,    32'h80000000,   5'd31, 32'hFFFFFFFF,  1'b0};
        vecs[7] = '{-8'sd3,   8'sd0,    32'd7,          5'd2,  32'hFFFFFFFB,  1'b0};
        vecs[8] = '{-8'sd6,   8'sd0,    32'd1,          5'd2,  32'hFFFFFFFF,  1'b0};
        vecs[9] = '{8'sd100,  -8'sd28,  32'd1000,       5'd3,  32'd16000,     1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_odata", dif.odata, 32'd0);
        chk("reset_valid", {31'd0, dif.odata_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_idata_ready", {31'd0, dif.idata_ready}, 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].x, vecs[i].zp, vecs[i].scale, vecs[i].shift, vecs[i].exp,
                    $sformatf("vec%0d", i));
`ifdef CORE_DEQUANT_SAT_CNT_EN
            if (vecs[i].sat) exp_sat_cnt++;
            chk($sformatf("vec%0d_sat_cnt", i), {16'd0, sat_cnt}, 32'(exp_sat_cnt));
`endif
        end

`ifdef CORE_DEQUANT_SAT_CNT_EN
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("sat_cnt_clear", {16'd0, sat_cnt}, 32'd0);
`endif

        stream_test();

        // fill all three stages while output is stalled, then reset mid-flight
        cfg_zp = 8'sd0; cfg_scale = 32'sd2; cfg_shift = 5'd0;
        dif.odata_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dif.idata       = 8'(i + 1);
            dif.idata_valid = 1'b1;
            @(posedge clk); #1;
        end
        dif.idata_valid = 1'b0;
        chk("inflight_busy", {31'd0, busy}, 32'd1);
        chk("inflight_valid", {31'd0, dif.odata_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, dif.odata_valid}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_odata", dif.odata, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_one(8'sd7, 8'sd0, 32'd5, 5'd0, 32'd35, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
